// File: rtl/bcd_counter_mux7seg.sv
// Multi-digit BCD up/down counter with prescaled count tick and a time-multiplexed,
// common-anode 7-segment scan driver (active-low seg and an).

module bcd_digit (
    input  logic       up,
    input  logic       cin,
    input  logic [3:0] d,
    output logic [3:0] nxt,
    output logic       cout
);
    always_comb begin
        nxt  = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d >= 4'd9) begin
                    nxt  = 4'd0;
                    cout = 1'b1;
                end else begin
                    nxt = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    nxt  = 4'd9;
                    cout = 1'b1;
                end else begin
                    nxt = d - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_counter_mux7seg #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 20000000,
    parameter int SCAN_DIV   = 20000,
    parameter int BLANK_LZ   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    carry,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]              presc;
    logic                       tick;
    logic [NUM_DIGITS-1:0][3:0] dig_q;
    logic [NUM_DIGITS-1:0][3:0] dig_nxt;
    logic [NUM_DIGITS-1:0][3:0] ld_dig;
    logic [NUM_DIGITS:0]        chain;
    logic [NUM_DIGITS:0]        hi_zero;
    logic [NUM_DIGITS-1:0]      blank;
    logic [SW-1:0]              scnt;
    logic [IW-1:0]              idx;
    logic [3:0]                 cur;
    logic [6:0]                 glyph;

    assign tick                = (presc == PW'(TICK_DIV - 1));
    assign chain[0]            = tick & en;
    assign hi_zero[NUM_DIGITS] = 1'b1;
    assign count               = dig_q;

    // chain[k] is the step request into digit k; the top one is the full-wrap flag
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        bcd_digit u_dig (
            .up   (up),
            .cin  (chain[k]),
            .d    (dig_q[k]),
            .nxt  (dig_nxt[k]),
            .cout (chain[k+1])
        );
        assign ld_dig[k]  = (load_val[4*k +: 4] > 4'd9) ? 4'd0 : load_val[4*k +: 4];
        assign hi_zero[k] = (dig_q[k] == 4'd0) && hi_zero[k+1];
        assign blank[k]   = (BLANK_LZ != 0) && (k > 0) && hi_zero[k];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            presc <= '0;
            dig_q <= '0;
            carry <= 1'b0;
        end else if (load) begin
            presc <= '0;
            dig_q <= ld_dig;
            carry <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            dig_q <= dig_nxt;
            carry <= chain[NUM_DIGITS];
        end
    end

    assign cur = dig_q[idx];

    always_comb begin
        glyph = 7'b1111111;
        case (cur)
            4'd0: glyph = 7'b0000001;
            4'd1: glyph = 7'b1001111;
            4'd2: glyph = 7'b0010010;
            4'd3: glyph = 7'b0000110;
            4'd4: glyph = 7'b1001100;
            4'd5: glyph = 7'b0100100;
            4'd6: glyph = 7'b0100000;
            4'd7: glyph = 7'b0001111;
            4'd8: glyph = 7'b0000000;
            4'd9: glyph = 7'b0000100;
            default: glyph = 7'b1111111;
        endcase
    end

    // an and seg both come from the same idx sample, so the digit and its glyph never skew
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt <= '0;
            idx  <= '0;
            an   <= ~NUM_DIGITS'(1);
            seg  <= 7'b0000001;
        end else begin
            if (scnt == SW'(SCAN_DIV - 1)) begin
                scnt <= '0;
                idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scnt <= scnt + 1'b1;
            end
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= blank[idx] ? 7'b1111111 : glyph;
        end
    end
endmodule
